tt_pin_bist_driver: RTL and testbench

//  Synthesizable pin-side driver/checker for a Tiny Tapeout user project: it owns the opposite end of the
//  ui_in/uo_out/uio/ena/rst_n interface. Runs a DUT reset pulse, then applies N LFSR-generated vectors to
//  ui_in/uio_in, samples uo_out and (uio_out & uio_oe) after a settle delay, and compacts them into a
//  16-bit MISR. Compares the final signature to expected_sig. Used for FPGA bring-up and for self-check in sim.

---
 rtl/tt_pin_bist_driver_if.sv | 21 ++
 rtl/tt_pin_bist_driver.sv | 194 +++++++++++++++++++
 tb/tb_tt_pin_bist_driver.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tt_pin_bist_driver_if.sv
// Pin bundle between the BIST driver and a Tiny Tapeout user design.
// The master drives the design's inputs and monitors its outputs.
interface tt_pin_bist_driver_if;
    logic [7:0] ui_in_drv;
    logic [7:0] uio_in_drv;
    logic       ena_drv;
    logic       dut_rst_n_drv;
    logic [7:0] uo_out_mon;
    logic [7:0] uio_out_mon;
    logic [7:0] uio_oe_mon;

    modport master (
        output ui_in_drv, uio_in_drv, ena_drv, dut_rst_n_drv,
        input  uo_out_mon, uio_out_mon, uio_oe_mon
    );

    modport slave (
        input  ui_in_drv, uio_in_drv, ena_drv, dut_rst_n_drv,
        output uo_out_mon, uio_out_mon, uio_oe_mon
    );
endinterface

// File: rtl/tt_pin_bist_driver.sv
// Pin-side BIST driver: resets the user design, drives LFSR vectors, compacts responses into a MISR.
// Optional macro TT_BIST_OE_CHECK_EN enables the uio_oe stability check (oe_err).
module tt_pin_bist_driver #(
    parameter int unsigned N_VECTORS     = 256,
    parameter int unsigned RESET_CYCLES  = 4,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter logic [15:0] MISR_SEED     = 16'hFFFF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic [15:0]                 expected_sig,
    tt_pin_bist_driver_if.master        pins,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [15:0]                 signature,
    output logic [15:0]                 vec_count,
    output logic                        oe_err,
    output logic [2:0]                  state_dbg
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DUT_RESET = 3'd1,
        S_SETTLE    = 3'd2,
        S_SAMPLE    = 3'd3,
        S_DONE      = 3'd4
    } state_e;

    localparam logic [15:0] RST_LAST  = 16'(RESET_CYCLES - 1);
    localparam logic [15:0] SET_LAST  = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] VEC_LAST  = 16'(N_VECTORS);
    // With no settle time each vector goes straight to its sample cycle.
    localparam state_e      FIRST_VEC = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;

    function automatic logic [15:0] step16(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] misr_q, misr_d;
    logic [15:0] vec_q, vec_d;
    logic [7:0]  ui_q, ui_d;
    logic [7:0]  uio_q, uio_d;
    logic        ena_q, ena_d;
    logic        rstn_q, rstn_d;
    logic        pass_q, pass_d;
    logic        oe_err_q, oe_err_d;
    logic [15:0] sample_word;

`ifdef TT_BIST_OE_CHECK_EN
    logic [7:0]  oe_ref_q, oe_ref_d;
`else
    assign oe_err_q = 1'b0;
`endif

    assign sample_word = {pins.uo_out_mon, pins.uio_out_mon & pins.uio_oe_mon};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lfsr_d   = lfsr_q;
        misr_d   = misr_q;
        vec_d    = vec_q;
        ui_d     = ui_q;
        uio_d    = uio_q;
        ena_d    = ena_q;
        rstn_d   = rstn_q;
        oe_err_d = oe_err_q;
`ifdef TT_BIST_OE_CHECK_EN
        oe_ref_d = oe_ref_q;
`endif
        if (abort) begin
            state_d  = S_IDLE;
            ui_d     = 8'h00;
            uio_d    = 8'h00;
            ena_d    = 1'b0;
            rstn_d   = 1'b0;
            oe_err_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d  = S_DUT_RESET;
                        cnt_d    = 16'd0;
                        lfsr_d   = LFSR_SEED;
                        misr_d   = MISR_SEED;
                        vec_d    = 16'd0;
                        ui_d     = 8'h00;
                        uio_d    = 8'h00;
                        ena_d    = 1'b1;
                        rstn_d   = 1'b0;
                        oe_err_d = 1'b0;
                    end
                end
                S_DUT_RESET: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = FIRST_VEC;
                        cnt_d   = 16'd0;
                        rstn_d  = 1'b1;
                        ui_d    = lfsr_q[7:0];
                        uio_d   = lfsr_q[15:8];
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == SET_LAST) begin
                        state_d = S_SAMPLE;
                        cnt_d   = 16'd0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                S_SAMPLE: begin
                    misr_d = step16(misr_q) ^ sample_word;
                    lfsr_d = step16(lfsr_q);
                    vec_d  = vec_q + 16'd1;
`ifdef TT_BIST_OE_CHECK_EN
                    if (vec_q == 16'd0) begin
                        oe_ref_d = pins.uio_oe_mon;
                    end else if (pins.uio_oe_mon != oe_ref_q) begin
                        oe_err_d = 1'b1;
                    end
`endif
                    // Pins keep the last vector once the run is complete.
                    if (vec_d == VEC_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = FIRST_VEC;
                        ui_d    = lfsr_d[7:0];
                        uio_d   = lfsr_d[15:8];
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        pass_d = (state_d == S_DONE) && (misr_d == expected_sig) && !oe_err_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            lfsr_q  <= LFSR_SEED;
            misr_q  <= MISR_SEED;
            vec_q   <= 16'd0;
            ui_q    <= 8'h00;
            uio_q   <= 8'h00;
            ena_q   <= 1'b0;
            rstn_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            vec_q   <= vec_d;
            ui_q    <= ui_d;
            uio_q   <= uio_d;
            ena_q   <= ena_d;
            rstn_q  <= rstn_d;
            pass_q  <= pass_d;
        end
    end

`ifdef TT_BIST_OE_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oe_ref_q <= 8'h00;
            oe_err_q <= 1'b0;
        end else begin
            oe_ref_q <= oe_ref_d;
            oe_err_q <= oe_err_d;
        end
    end
`endif

    assign pins.ui_in_drv     = ui_q;
    assign pins.uio_in_drv    = uio_q;
    assign pins.ena_drv       = ena_q;
    assign pins.dut_rst_n_drv = rstn_q;
    assign busy      = (state_q == S_DUT_RESET) || (state_q == S_SETTLE) || (state_q == S_SAMPLE);
    assign done      = (state_q == S_DONE);
    assign pass      = pass_q;
    assign signature = misr_q;
    assign vec_count = vec_q;
    assign oe_err    = oe_err_q;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_tt_pin_bist_driver.sv
// Bench for tt_pin_bist_driver: loopback user design, directed runs, done-triggered scoreboard.
module tb_tt_pin_bist_driver;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // main instance: RESET_CYCLES=2, SETTLE_CYCLES=1, N_VECTORS=4
    tt_pin_bist_driver_if pif ();
    logic        start, abort;
    logic [15:0] expected_sig;
    logic        busy, done, pass, oe_err;
    logic [15:0] signature, vec_count;
    logic [2:0]  state_dbg;
    logic [7:0]  uio_out_val, oe_val;

    assign pif.uo_out_mon  = pif.ui_in_drv;
    assign pif.uio_out_mon = uio_out_val;
    assign pif.uio_oe_mon  = oe_val;

    tt_pin_bist_driver #(.N_VECTORS(4), .RESET_CYCLES(2), .SETTLE_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .expected_sig(expected_sig),
        .pins(pif), .busy(busy), .done(done), .pass(pass), .signature(signature),
        .vec_count(vec_count), .oe_err(oe_err), .state_dbg(state_dbg)
    );

    // second instance: no settle time, RESET_CYCLES=1, N_VECTORS=3
    tt_pin_bist_driver_if pif0 ();
    logic        start0;
    logic [15:0] expected_sig0;
    logic        busy0, done0, pass0, oe_err0;
    logic [15:0] signature0, vec_count0;
    logic [2:0]  state_dbg0;

    assign pif0.uo_out_mon  = pif0.ui_in_drv;
    assign pif0.uio_out_mon = 8'h00;
    assign pif0.uio_oe_mon  = 8'h00;

    tt_pin_bist_driver #(.N_VECTORS(3), .RESET_CYCLES(1), .SETTLE_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(1'b0), .expected_sig(expected_sig0),
        .pins(pif0), .busy(busy0), .done(done0), .pass(pass0), .signature(signature0),
        .vec_count(vec_count0), .oe_err(oe_err0), .state_dbg(state_dbg0)
    );

    // scoreboard entry: {pass, vec_count, signature}
    logic [32:0] exp_q[$];
    logic [32:0] mon_e;
    logic        done_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Signature of an n-vector run against a loopback design whose masked uio bits are 'low'.
    function automatic logic [15:0] sig_model(input int n, input logic [7:0] low);
        logic [15:0] l, m;
        l = 16'hACE1;
        m = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            m = lfsr_step(m) ^ {l[7:0], low};
            l = lfsr_step(l);
        end
        return m;
    endfunction

    function automatic logic [15:0] lfsr_nth(input int n);
        logic [15:0] l;
        l = 16'hACE1;
        for (int i = 0; i < n; i++) l = lfsr_step(l);
        return l;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sb_signature", {16'h0, signature}, {16'h0, mon_e[15:0]});
                    check("sb_vec_count", {16'h0, vec_count}, {16'h0, mon_e[31:16]});
                    check("sb_pass", {31'h0, pass}, {31'h0, mon_e[32]});
                end
            end
            done_prev = done;
        end
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("done_within_budget", {31'h0, done}, 32'd1);
    endtask

    task automatic wait_vec(input logic [15:0] target, input int limit);
        int n = 0;
        while (vec_count != target && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("vec_reached", {16'h0, vec_count}, {16'h0, target});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [15:0] m4, m4f, m3;

    initial begin
        m4  = sig_model(4, 8'h00);
        m4f = sig_model(4, 8'h0F);
        m3  = sig_model(3, 8'h00);
        rst = 1'b1; start = 1'b0; abort = 1'b0; start0 = 1'b0;
        expected_sig = 16'h0000; expected_sig0 = m3;
        uio_out_val = 8'h00; oe_val = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // reset state
        check("rst_ui", {24'h0, pif.ui_in_drv}, 32'h0);
        check("rst_uio", {24'h0, pif.uio_in_drv}, 32'h0);
        check("rst_ena", {31'h0, pif.ena_drv}, 32'h0);
        check("rst_rstn", {31'h0, pif.dut_rst_n_drv}, 32'h0);
        check("rst_busy_done_pass", {29'h0, busy, done, pass}, 32'h0);
        check("rst_sig", {16'h0, signature}, 32'hFFFF);
        check("rst_vec", {16'h0, vec_count}, 32'h0);
        check("rst_oe_err", {31'h0, oe_err}, 32'h0);

        // run A: loopback, matching signature, cycle-by-cycle timing
        expected_sig = m4;
        exp_q.push_back({1'b1, 16'd4, m4});
        pulse_start();
        check("a_e0_busy", {31'h0, busy}, 32'd1);
        check("a_e0_rstn", {31'h0, pif.dut_rst_n_drv}, 32'd0);
        check("a_e0_ena", {31'h0, pif.ena_drv}, 32'd1);
        check("a_e0_pins", {16'h0, pif.uio_in_drv, pif.ui_in_drv}, 32'h0);
        @(negedge clk);
        check("a_e1_rstn", {31'h0, pif.dut_rst_n_drv}, 32'd0);
        @(negedge clk);
        check("a_e2_rstn", {31'h0, pif.dut_rst_n_drv}, 32'd1);
        check("a_vec1_pins", {16'h0, pif.uio_in_drv, pif.ui_in_drv}, 32'h0000ACE1);
        @(negedge clk);
        check("a_e3_hold", {16'h0, pif.uio_in_drv, pif.ui_in_drv}, 32'h0000ACE1);
        @(negedge clk);
        check("a_vec2_pins", {16'h0, pif.uio_in_drv, pif.ui_in_drv}, 32'h000059C3);
        check("a_e4_vec", {16'h0, vec_count}, 32'd1);
        repeat (5) @(negedge clk);
        check("a_e9_done", {30'h0, busy, done}, 32'b10);
        @(negedge clk);
        check("a_e10_done", {30'h0, busy, done}, 32'b01);
        check("a_e10_ena", {31'h0, pif.ena_drv}, 32'd1);
        check("a_last_pins", {16'h0, pif.uio_in_drv, pif.ui_in_drv}, {16'h0, lfsr_nth(3)});

        // run B from DONE: wrong golden by one bit, DUT reset pulse length
        expected_sig = m4 ^ 16'h0001;
        exp_q.push_back({1'b0, 16'd4, m4});
        check("b_pre_rstn", {31'h0, pif.dut_rst_n_drv}, 32'd1);
        pulse_start();
        check("b_e0_rstn", {31'h0, pif.dut_rst_n_drv}, 32'd0);
        check("b_e0_done_pass", {30'h0, done, pass}, 32'd0);
        @(negedge clk);
        check("b_e1_rstn", {31'h0, pif.dut_rst_n_drv}, 32'd0);
        @(negedge clk);
        check("b_e2_rstn", {31'h0, pif.dut_rst_n_drv}, 32'd1);
        wait_done(20);

        // run C: uio_out all ones but masked off by uio_oe=0
        uio_out_val = 8'hFF; oe_val = 8'h00;
        expected_sig = m4;
        exp_q.push_back({1'b1, 16'd4, m4});
        pulse_start();
        wait_done(20);

        // run D: partially enabled uio bits reach the MISR
        uio_out_val = 8'hFF; oe_val = 8'h0F;
        expected_sig = m4f;
        exp_q.push_back({1'b1, 16'd4, m4f});
        pulse_start();
        wait_done(20);

        // run E: abort at vector 2 with start held high, then restart
        uio_out_val = 8'h00; oe_val = 8'h00;
        expected_sig = m4;
        pulse_start();
        wait_vec(16'd2, 20);
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        check("e_abort_busy_done", {30'h0, busy, done}, 32'd0);
        check("e_abort_pins", {16'h0, pif.uio_in_drv, pif.ui_in_drv}, 32'h0);
        check("e_abort_ena_rstn", {30'h0, pif.ena_drv, pif.dut_rst_n_drv}, 32'd0);
        check("e_abort_vec_kept", {16'h0, vec_count}, 32'd2);
        exp_q.push_back({1'b1, 16'd4, m4});
        abort = 1'b0;
        @(negedge clk) start = 1'b0;
        check("e_restart_busy", {31'h0, busy}, 32'd1);
        wait_done(20);

        // run F: uio_oe changes before vector 3
        oe_val = 8'h0F;
        expected_sig = m4;
`ifdef TT_BIST_OE_CHECK_EN
        exp_q.push_back({1'b0, 16'd4, m4});
`else
        exp_q.push_back({1'b1, 16'd4, m4});
`endif
        pulse_start();
        wait_vec(16'd2, 20);
        oe_val = 8'h1F;
        wait_done(20);
`ifdef TT_BIST_OE_CHECK_EN
        check("f_oe_err", {31'h0, oe_err}, 32'd1);
`else
        check("f_oe_err", {31'h0, oe_err}, 32'd0);
`endif
        @(negedge clk) abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        check("f_oe_err_cleared", {31'h0, oe_err}, 32'd0);
        oe_val = 8'h00;

        // zero-settle instance: vectors sampled back to back
        @(negedge clk) start0 = 1'b1;
        @(posedge clk);
        @(negedge clk) start0 = 1'b0;
        check("z_e0_busy", {31'h0, busy0}, 32'd1);
        @(negedge clk);
        check("z_e1_pins", {16'h0, pif0.uio_in_drv, pif0.ui_in_drv}, 32'h0000ACE1);
        check("z_e1_rstn", {31'h0, pif0.dut_rst_n_drv}, 32'd1);
        repeat (2) @(negedge clk);
        check("z_e3_done", {31'h0, done0}, 32'd0);
        @(negedge clk);
        check("z_e4_done", {30'h0, busy0, done0}, 32'b01);
        check("z_sig", {16'h0, signature0}, {16'h0, m3});
        check("z_pass", {31'h0, pass0}, 32'd1);

        @(negedge clk);
        check("sb_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
